pipe_fetch: RTL and testbench

PIPE_FETCH -- requirements
Module: pipe_fetch

---
 rtl/y86_pkg.sv | 71 +++++++
 rtl/imem_bytes.sv | 51 +++++
 rtl/pipe_fetch.sv | 158 +++++++++++++++
 tb/tb_pipe_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 fetch definitions.
//   icode constants, stat codes, register-none, D-register payload type and
//   bubble constant, fetch FSM states, and small instruction-format helpers.
package y86_pkg;

  localparam int unsigned NLANES = 10;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  64'h0,
    valp:  64'h0
  };

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_e;

  // Encoded length in bytes; unknown icodes take one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
      I_JXX, I_CALL:                    len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
      default:                          len = 4'd1;
    endcase
    return len;
  endfunction

  function automatic logic has_regids(input logic [3:0] icode);
    return (icode == I_RRMOVQ) || (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
           (icode == I_MRMOVQ) || (icode == I_OPQ) || (icode == I_PUSHQ) ||
           (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/imem_bytes.sv
// imem_bytes: byte-addressed instruction memory with NLANES combinational
// read lanes starting at i_addr.
//   i_addr      : base read address
//   o_lanes     : byte at i_addr+k in lane k (0 when out of range)
//   o_lane_oor  : lane k address is >= IMEM_BYTES
// With FETCH_IMEM_WR_EN defined: clk, imem_we, imem_waddr, imem_wdata form a
// synchronous byte write port; reads in the write cycle see the old byte.
// Without it the contents are fixed from elaboration onward.
module imem_bytes
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 4096
) (
`ifdef FETCH_IMEM_WR_EN
  input  logic                    clk,
  input  logic                    imem_we,
  input  logic [63:0]             imem_waddr,
  input  logic [7:0]              imem_wdata,
`endif
  input  logic [63:0]             i_addr,
  output logic [NLANES-1:0][7:0]  o_lanes,
  output logic [NLANES-1:0]       o_lane_oor
);

  localparam int unsigned AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

`ifdef FETCH_IMEM_WR_EN
  logic [7:0] r_mem [IMEM_BYTES];

  // Write port; only in-range addresses modify memory.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < 64'(IMEM_BYTES))) begin
      r_mem[imem_waddr[AW-1:0]] <= imem_wdata;
    end
  end
`else
  logic [7:0] r_mem [IMEM_BYTES] = '{default: 8'h00};
`endif

  logic [63:0] w_addr [NLANES];

  // Read lanes; out-of-range lanes return zero and raise their flag.
  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      w_addr[k]     = i_addr + 64'(k);
      o_lane_oor[k] = (w_addr[k] >= 64'(IMEM_BYTES));
      o_lanes[k]    = o_lane_oor[k] ? 8'h00 : r_mem[w_addr[k][AW-1:0]];
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: Y86-64 fetch stage with D pipeline register and RUN/HALTED FSM.
//   clk, rst (async, active high)
//   F_stall / D_stall / D_bubble : pipeline control
//   M_mispredict, M_valA : not-taken jXX correction (fall-through PC)
//   W_ret, W_valM        : ret in W with its return address
//   D_*                  : registered D-stage fields
//   F_predPC             : registered predicted PC
//   f_pc                 : combinational selected fetch PC
// Optional macro FETCH_IMEM_WR_EN adds imem_we/imem_waddr/imem_wdata.
module pipe_fetch
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 4096,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_IMEM_WR_EN
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
`endif
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        M_mispredict,
  input  logic [63:0] M_valA,
  input  logic        W_ret,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [63:0] F_predPC,
  output logic [63:0] f_pc
);

  fetch_state_e r_state, w_state_nxt;
  d_reg_t       r_d, w_d_nxt, w_fetch;
  logic [63:0]  r_pred_pc, w_pred_nxt, w_pred_pc, w_valp;
  logic [NLANES-1:0][7:0] w_lanes;
  logic [NLANES-1:0]      w_lane_oor;
  logic [3:0]   w_icode, w_ifun, w_len;
  logic         w_adr, w_ins, w_run, w_load_fetch;

  // Fetch PC select: mispredict correction beats ret, which beats prediction.
  always_comb begin
    if (M_mispredict)  f_pc = M_valA;
    else if (W_ret)    f_pc = W_valM;
    else               f_pc = r_pred_pc;
  end

  imem_bytes #(.IMEM_BYTES(IMEM_BYTES)) u_imem (
`ifdef FETCH_IMEM_WR_EN
    .clk        (clk),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
`endif
    .i_addr     (f_pc),
    .o_lanes    (w_lanes),
    .o_lane_oor (w_lane_oor)
  );

  // Instruction decode, status and predicted PC.
  always_comb begin
    w_icode = w_lanes[0][7:4];
    w_ifun  = w_lanes[0][3:0];
    w_len   = instr_len(w_icode);
    w_valp  = f_pc + 64'(w_len);
    w_fetch = D_BUBBLE;

    if (has_regids(w_icode)) begin
      w_fetch.ra = w_lanes[1][7:4];
      w_fetch.rb = w_lanes[1][3:0];
    end

    if ((w_icode == I_IRMOVQ) || (w_icode == I_RMMOVQ) || (w_icode == I_MRMOVQ)) begin
      w_fetch.valc = w_lanes[9:2];
    end else if ((w_icode == I_JXX) || (w_icode == I_CALL)) begin
      w_fetch.valc = w_lanes[8:1];
    end

    w_fetch.valp = w_valp;
    w_pred_pc    = ((w_icode == I_JXX) || (w_icode == I_CALL)) ? w_fetch.valc : w_valp;

    // Last byte of the instruction (or its first) past the end of memory.
    w_adr = w_lane_oor[0] || w_lane_oor[w_len - 4'd1];
    w_ins = (w_icode > I_POPQ);

    if (w_adr)                  w_fetch.stat = STAT_ADR;
    else if (w_ins)             w_fetch.stat = STAT_INS;
    else if (w_icode == I_HALT) w_fetch.stat = STAT_HLT;
    else                        w_fetch.stat = STAT_AOK;

    if (w_adr || w_ins) begin
      w_fetch.icode = I_NOP;
      w_fetch.ifun  = 4'h0;
    end else begin
      w_fetch.icode = w_icode;
      w_fetch.ifun  = w_ifun;
    end
  end

  // Next-state and register loads; a mispredict while HALTED fetches normally.
  always_comb begin
    w_state_nxt  = r_state;
    w_d_nxt      = r_d;
    w_pred_nxt   = r_pred_pc;
    w_run        = (r_state == S_RUN) || M_mispredict;
    w_load_fetch = 1'b0;

    if (!D_stall) begin
      if (D_bubble || !w_run) begin
        w_d_nxt = D_BUBBLE;
      end else begin
        w_d_nxt      = w_fetch;
        w_load_fetch = 1'b1;
      end
    end

    if (!F_stall && w_run) begin
      w_pred_nxt = w_pred_pc;
    end

    if (w_load_fetch && (w_fetch.stat != STAT_AOK) && !M_mispredict) begin
      w_state_nxt = S_HALTED;
    end else if ((r_state == S_HALTED) && M_mispredict) begin
      w_state_nxt = S_RUN;
    end
  end

  // State, D register and predicted PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_d       <= D_BUBBLE;
      r_pred_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_d       <= w_d_nxt;
      r_pred_pc <= w_pred_nxt;
    end
  end

  assign D_stat   = r_d.stat;
  assign D_icode  = r_d.icode;
  assign D_ifun   = r_d.ifun;
  assign D_rA     = r_d.ra;
  assign D_rB     = r_d.rb;
  assign D_valC   = r_d.valc;
  assign D_valP   = r_d.valp;
  assign F_predPC = r_pred_pc;

endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: table-driven fetch vectors plus hand sequences for stall,
// halt, recovery and asynchronous reset; expected D contents go through a
// scoreboard queue and are compared one cycle after being driven.
module tb_pipe_fetch;

  localparam int unsigned IMEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, D_stall, D_bubble, M_mispredict, W_ret;
  logic [63:0] M_valA, W_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP, F_predPC, f_pc;

  pipe_fetch #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .D_bubble     (D_bubble),
    .M_mispredict (M_mispredict),
    .M_valA       (M_valA),
    .W_ret        (W_ret),
    .W_valM       (W_valM),
    .D_stat       (D_stat),
    .D_icode      (D_icode),
    .D_ifun       (D_ifun),
    .D_rA         (D_rA),
    .D_rB         (D_rB),
    .D_valC       (D_valC),
    .D_valP       (D_valP),
    .F_predPC     (F_predPC),
    .f_pc         (f_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pred;
    logic        chk_valc;
  } exp_t;

  // sel: 0 = reach pc via W_ret, 1 = via M_mispredict, 2 = both (mispredict wins)
  typedef struct {
    logic [63:0] pc;
    int          sel;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                              input logic [63:0] vp, input logic [63:0] pr, input logic cv);
    exp_t e;
    e.stat = st; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.pred = pr; e.chk_valc = cv;
    return e;
  endfunction

  function automatic exp_t bub(input logic [63:0] pr);
    return mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, pr, 1'b1);
  endfunction

  function automatic vec_t mv(input logic [63:0] pc, input int sel, input exp_t e);
    vec_t v;
    v.pc = pc; v.sel = sel; v.e = e;
    return v;
  endfunction

  // Place n bytes at address a; first byte in the top byte of b.
  task automatic put(input logic [63:0] a, input logic [79:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      dut.u_imem.r_mem[a + 64'(k)] = b[79 - 8*k -: 8];
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " stat"},  64'(D_stat),  64'(e.stat));
    chk({tag, " icode"}, 64'(D_icode), 64'(e.icode));
    chk({tag, " ifun"},  64'(D_ifun),  64'(e.ifun));
    chk({tag, " rA"},    64'(D_rA),    64'(e.ra));
    chk({tag, " rB"},    64'(D_rB),    64'(e.rb));
    if (e.chk_valc) chk({tag, " valC"}, D_valC, e.valc);
    chk({tag, " valP"},  D_valP,   e.valp);
    chk({tag, " predPC"}, F_predPC, e.pred);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic clr_ctl();
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_mispredict = 1'b0; M_valA = 64'h0; W_ret = 1'b0; W_valM = 64'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr_ctl();

    vt[0]  = mv(64'h0,  0, mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd10, 1'b1));
    vt[1]  = mv(64'h10, 0, mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h19, 64'h40, 1'b1));
    vt[2]  = mv(64'h19, 2, mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1A, 64'h1A, 1'b1));
    vt[3]  = mv(64'h20, 0, mk(3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h22, 64'h22, 1'b1));
    vt[4]  = mv(64'h30, 0, mk(3'd1, 4'h6, 4'h1, 4'hA, 4'hB, 64'h0, 64'h32, 64'h32, 1'b1));
    vt[5]  = mv(64'h40, 0, mk(3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 64'h41, 1'b1));
    vt[6]  = mv(64'h50, 0, mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 64'h51, 1'b1));
    vt[7]  = mv(64'h60, 0, mk(3'd1, 4'h4, 4'h0, 4'h3, 4'h7, 64'h1122334455667788, 64'h6A, 64'h6A, 1'b1));
    vt[8]  = mv(64'h70, 0, mk(3'd1, 4'h5, 4'h0, 4'h4, 4'h5, 64'hDEADBEEF, 64'h7A, 64'h7A, 1'b1));
    vt[9]  = mv(64'h80, 0, mk(3'd1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h100, 64'h89, 64'h100, 1'b1));
    vt[10] = mv(64'h90, 0, mk(3'd1, 4'hA, 4'h0, 4'h6, 4'hF, 64'h0, 64'h92, 64'h92, 1'b1));
    vt[11] = mv(64'hA0, 0, mk(3'd1, 4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'hA2, 64'hA2, 1'b1));
    vt[12] = mv(64'hB0, 0, mk(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'hB9, 64'h1234, 1'b1));
    vt[13] = mv(64'hC0, 1, mk(3'd4, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'hC1, 64'hC1, 1'b1));
    vt[14] = mv(64'(IMEM_BYTES - 5), 1,
                mk(3'd3, 4'h1, 4'h0, 4'hF, 4'h3, 64'h0, 64'(IMEM_BYTES + 5), 64'(IMEM_BYTES + 5), 1'b0));
    vt[15] = mv(64'h20, 2, mk(3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h22, 64'h22, 1'b1));

    for (int a = 0; a < int'(IMEM_BYTES); a++) dut.u_imem.r_mem[a] = 8'h00;
    put(64'h0,  80'h30F20A00000000000000, 10);
    put(64'h10, 80'h70400000000000000000, 9);
    put(64'h20, 80'h20120000000000000000, 2);
    put(64'h30, 80'h61AB0000000000000000, 2);
    put(64'h40, 80'h90000000000000000000, 1);
    put(64'h50, 80'h10000000000000000000, 1);
    put(64'h60, 80'h40378877665544332211, 10);
    put(64'h70, 80'h5045EFBEADDE00000000, 10);
    put(64'h80, 80'h73000100000000000000, 9);
    put(64'h90, 80'hA06F0000000000000000, 2);
    put(64'hA0, 80'hB07F0000000000000000, 2);
    put(64'hB0, 80'h80341200000000000000, 9);
    put(64'hC0, 80'hC0000000000000000000, 1);
    put(64'(IMEM_BYTES - 5), 80'h30F30000000000000000, 2);

    // Reset state, sampled between edges.
    #12;
    sb.push_back(bub(64'h0));
    pop_check("reset");
    chk("reset f_pc", f_pc, 64'h0);
    rst = 1'b0;

    // First fetch from the predicted PC after reset (irmovq at 0).
    #1;
    chk("first f_pc", f_pc, 64'h0);
    sb.push_back(vt[0].e);
    tick("first");

    // Table: redirect fetch via W_ret / M_mispredict.
    for (int i = 0; i < 16; i++) begin
      clr_ctl();
      if (vt[i].sel == 0) begin
        W_ret = 1'b1; W_valM = vt[i].pc;
      end else if (vt[i].sel == 1) begin
        M_mispredict = 1'b1; M_valA = vt[i].pc;
      end else begin
        M_mispredict = 1'b1; M_valA = vt[i].pc;
        W_ret = 1'b1; W_valM = 64'h50;
      end
      #1;
      chk($sformatf("vec%0d f_pc", i), f_pc, vt[i].pc);
      sb.push_back(vt[i].e);
      tick($sformatf("vec%0d", i));
    end

    // D_stall with D_bubble holds D; F_stall holds F_predPC.
    clr_ctl();
    D_stall = 1'b1; D_bubble = 1'b1; F_stall = 1'b1; W_ret = 1'b1; W_valM = 64'h60;
    sb.push_back(vt[15].e);
    tick("stall_both");
    clr_ctl();
    D_bubble = 1'b1; W_ret = 1'b1; W_valM = 64'h20;
    sb.push_back(bub(64'h22));
    tick("bubble");
    clr_ctl();
    D_stall = 1'b1; W_ret = 1'b1; W_valM = 64'h30;
    sb.push_back(bub(64'h32));
    tick("dstall_only");

    // Load a real instruction, then reset between edges.
    clr_ctl();
    W_ret = 1'b1; W_valM = 64'h60;
    sb.push_back(vt[7].e);
    tick("pre_reset");
    clr_ctl();
    rst = 1'b1;
    #1;
    sb.push_back(bub(64'h0));
    pop_check("async_reset_run");
    put(64'h0, 80'h00000000000000000000, 1);
    #2;
    rst = 1'b0;

    // halt at 0: HLT into D, then held PC and bubbles.
    sb.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 1'b1));
    tick("halt");
    chk("halted f_pc", f_pc, 64'h1);
    sb.push_back(bub(64'h1));
    tick("halted1");
    W_ret = 1'b1; W_valM = 64'h20;
    sb.push_back(bub(64'h1));
    tick("halted_ret");
    clr_ctl();

    // Reset while HALTED, between edges.
    rst = 1'b1;
    #1;
    sb.push_back(bub(64'h0));
    pop_check("async_reset_halted");
    #2;
    rst = 1'b0;
    sb.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 1'b1));
    tick("halt_again");

    // Recovery from HALTED via mispredict, then halt again at 0x22.
    M_mispredict = 1'b1; M_valA = 64'h20;
    #1;
    chk("recover f_pc", f_pc, 64'h20);
    sb.push_back(vt[3].e);
    tick("recover");
    clr_ctl();
    #1;
    chk("post_recover f_pc", f_pc, 64'h22);
    sb.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h23, 64'h23, 1'b1));
    tick("halt_0x22");
    sb.push_back(bub(64'h23));
    tick("halted2");

    chk("sb drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
